// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop sequencer.
package riscv_hwloop_pkg;

  localparam int unsigned HWLP_ADDR_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address compare plus lowest-index priority pick.
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = 2,
  parameter int unsigned N_REG_BITS = 1
) (
  input  logic [HWLP_ADDR_W-1:0]             current_pc_i,
  input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] end_addr_i,
  input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] counter_i,
  output logic [N_REGS-1:0]                  active_o,
  output logic                               hit_o,
  output logic [N_REG_BITS-1:0]              sel_o,
  output logic [N_REGS-1:0]                  onehot_o
);

  logic [N_REGS-1:0] match;

  always_comb begin
    active_o = '0;
    match    = '0;
    for (int i = 0; i < N_REGS; i++) begin
      active_o[i] = (counter_i[i] != '0);
      match[i]    = active_o[i] && (current_pc_i == end_addr_i[i]);
    end
  end

  // Scan from the outermost loop down so the innermost match is written last and wins.
  always_comb begin
    hit_o    = |match;
    sel_o    = '0;
    onehot_o = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_o       = N_REG_BITS'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop sequencer: end-PC match, counter decrement and fetch redirect with hold.
module riscv_hwloop_sequencer
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = 2,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [HWLP_ADDR_W-1:0]             current_pc_i,
  input  logic                               pc_valid_i,
  input  logic                               kill_i,
  input  logic                               fetch_ready_i,
  input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_counter_i,
  output logic [N_REGS-1:0]                  hwlp_dec_cnt_o,
  output logic                               hwlp_valid_o,
  output logic                               hwlp_jump_o,
  output logic [HWLP_ADDR_W-1:0]             hwlp_targ_addr_o,
  output logic [N_REGS-1:0]                  hwlp_active_o,
  output logic                               busy_o
);

  hwlp_state_e             state_q, state_d;
  logic [HWLP_ADDR_W-1:0]  targ_q, targ_d;

  logic                    match_hit;
  logic [N_REG_BITS-1:0]   match_sel;
  logic [N_REGS-1:0]       match_onehot;
  logic [HWLP_ADDR_W-1:0]  sel_cnt;
  logic                    more_iters;

  riscv_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .current_pc_i (current_pc_i),
    .end_addr_i   (hwlp_end_addr_i),
    .counter_i    (hwlp_counter_i),
    .active_o     (hwlp_active_o),
    .hit_o        (match_hit),
    .sel_o        (match_sel),
    .onehot_o     (match_onehot)
  );

  assign sel_cnt    = hwlp_counter_i[match_sel];
  assign more_iters = (sel_cnt != '0) && (sel_cnt != HWLP_ADDR_W'(1));

  always_comb begin
    state_d          = state_q;
    targ_d           = targ_q;
    hwlp_dec_cnt_o   = '0;
    hwlp_valid_o     = 1'b0;
    hwlp_jump_o      = 1'b0;
    hwlp_targ_addr_o = '0;
    unique case (state_q)
      StIdle: begin
        if (pc_valid_i && !kill_i && match_hit) begin
          hwlp_dec_cnt_o = match_onehot;
          hwlp_valid_o   = 1'b1;
          if (more_iters) begin
            hwlp_jump_o      = 1'b1;
            hwlp_targ_addr_o = hwlp_start_addr_i[match_sel];
            if (!fetch_ready_i) begin
              state_d = StHold;
              targ_d  = hwlp_start_addr_i[match_sel];
            end
          end
        end
      end
      StHold: begin
        // Decrement already happened in the hit cycle; only the redirect is outstanding.
        if (kill_i) begin
          state_d = StIdle;
        end else begin
          hwlp_jump_o      = 1'b1;
          hwlp_targ_addr_o = targ_q;
          if (fetch_ready_i) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q == StHold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      targ_q  <= '0;
    end else begin
      state_q <= state_d;
      targ_q  <= targ_d;
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Directed self-checking bench for riscv_hwloop_sequencer; a tiny counter model stands in
// for the hwloop register file.
module tb_riscv_hwloop_sequencer;

  logic              clk;
  logic              rst_n;
  logic [31:0]       current_pc;
  logic              pc_valid;
  logic              kill;
  logic              fetch_ready;
  logic [1:0][31:0]  st;
  logic [1:0][31:0]  en;
  logic [1:0][31:0]  cnt;
  logic [1:0]        dec;
  logic              valid;
  logic              jump;
  logic [31:0]       targ;
  logic [1:0]        active;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  riscv_hwloop_sequencer #(
    .N_REGS (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_pc_i      (current_pc),
    .pc_valid_i        (pc_valid),
    .kill_i            (kill),
    .fetch_ready_i     (fetch_ready),
    .hwlp_start_addr_i (st),
    .hwlp_end_addr_i   (en),
    .hwlp_counter_i    (cnt),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_valid_o      (valid),
    .hwlp_jump_o       (jump),
    .hwlp_targ_addr_o  (targ),
    .hwlp_active_o     (active),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the register-file model applies any decrement just after the edge.
  task automatic tick();
    logic [1:0] cap;
    cap = valid ? dec : 2'b00;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (cap[i]) cnt[i] = cnt[i] - 32'd1;
  endtask

  task automatic outs(input string tag, input logic [1:0] e_dec, input logic e_valid,
                      input logic e_jump, input logic [31:0] e_targ, input logic e_busy);
    #1;
    chk({tag, ".dec"},   {30'd0, dec},   {30'd0, e_dec});
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    chk({tag, ".jump"},  {31'd0, jump},  {31'd0, e_jump});
    chk({tag, ".targ"},  targ,           e_targ);
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, e_busy});
  endtask

  initial begin
    rst_n       = 1'b0;
    current_pc  = 32'h0;
    pc_valid    = 1'b0;
    kill        = 1'b0;
    fetch_ready = 1'b1;
    st[0] = 32'h100; en[0] = 32'h10C; cnt[0] = 32'd0;
    st[1] = 32'h400; en[1] = 32'h500; cnt[1] = 32'd0;
    #2;
    outs("reset", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset.active", {30'd0, active}, 32'h0);

    // Single loop, three iterations
    #10;
    rst_n      = 1'b1;
    cnt[0]     = 32'd3;
    current_pc = 32'h10C;
    pc_valid   = 1'b1;
    outs("l1.it1", 2'b01, 1'b1, 1'b1, 32'h100, 1'b0);
    chk("l1.active", {30'd0, active}, 32'h1);
    tick();
    outs("l1.it2", 2'b01, 1'b1, 1'b1, 32'h100, 1'b0);
    tick();
    outs("l1.it3", 2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("l1.cnt_end", cnt[0], 32'd0);
    // Matching PC but counter exhausted: no activity
    outs("l1.cnt0", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("l1.active0", {30'd0, active}, 32'h0);

    // Nested loops sharing an end address
    st[0] = 32'h1F0; en[0] = 32'h200; cnt[0] = 32'd1;
    st[1] = 32'h180; en[1] = 32'h200; cnt[1] = 32'd2;
    current_pc = 32'h200;
    outs("nest.inner", 2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("nest.active", {30'd0, active}, 32'h3);
    tick();
    outs("nest.outer", 2'b10, 1'b1, 1'b1, 32'h180, 1'b0);
    tick();
    chk("nest.cnt1", cnt[1], 32'd1);
    pc_valid = 1'b0;
    outs("nest.novalid", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

    // Hold while IF is not ready
    st[0] = 32'h300; en[0] = 32'h33C; cnt[0] = 32'd5;
    cnt[1] = 32'd0;
    current_pc  = 32'h33C;
    pc_valid    = 1'b1;
    fetch_ready = 1'b0;
    outs("hold.hit", 2'b01, 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    st[0] = 32'h999;
    for (int c = 0; c < 3; c++) begin
      outs($sformatf("hold.c%0d", c), 2'b00, 1'b0, 1'b1, 32'h300, 1'b1);
      tick();
    end
    fetch_ready = 1'b1;
    outs("hold.accept", 2'b00, 1'b0, 1'b1, 32'h300, 1'b1);
    pc_valid = 1'b0;
    tick();
    outs("hold.idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hold.cnt", cnt[0], 32'd4);

    // Kill while holding
    st[0]       = 32'h300;
    pc_valid    = 1'b1;
    fetch_ready = 1'b0;
    outs("kh.hit", 2'b01, 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    kill = 1'b1;
    outs("kh.kill", 2'b00, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    kill     = 1'b0;
    pc_valid = 1'b0;
    outs("kh.idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("kh.cnt", cnt[0], 32'd3);

    // Kill in a hit cycle overrides fetch_ready
    pc_valid    = 1'b1;
    kill        = 1'b1;
    fetch_ready = 1'b1;
    outs("kc.kill", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    pc_valid = 1'b0;
    kill     = 1'b0;
    outs("kc.idle", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("kc.cnt", cnt[0], 32'd3);

    // Asynchronous reset in the middle of HOLD
    pc_valid    = 1'b1;
    fetch_ready = 1'b0;
    outs("rh.hit", 2'b01, 1'b1, 1'b1, 32'h300, 1'b0);
    tick();
    pc_valid = 1'b0;
    outs("rh.hold", 2'b00, 1'b0, 1'b1, 32'h300, 1'b1);
    #2;
    rst_n = 1'b0;
    outs("rh.rst", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_ready = 1'b1;
    outs("rh.after", 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_sequencer.md
# riscv_hwloop_sequencer

Sequences the RI5CY hardware-loop register file. Each cycle it checks the PC of the instruction issuing in ID against every loop's end address. On a match it picks the innermost active loop, pulses that loop's counter decrement, and, if iterations remain, redirects fetch to the loop start. When the IF stage cannot take the redirect immediately, the block holds the jump target until IF accepts it. It sits between the hwloop registers and the IF/ID controller.

## Interface
- N_REGS, 2, number of hardware-loop register sets; index 0 is the innermost loop and has the highest priority
- N_REG_BITS, $clog2(N_REGS), width of a loop index
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- current_pc_i  in  32  PC of the instruction in ID
- pc_valid_i  in  1  instruction at current_pc_i issues this cycle
- kill_i  in  1  flush (exception, debug, branch): cancels any jump
- fetch_ready_i  in  1  IF accepts a redirect this cycle
- hwlp_start_addr_i  in  N_REGS×32  loop start addresses
- hwlp_end_addr_i  in  N_REGS×32  loop end addresses (address of the last instruction in the body)
- hwlp_counter_i  in  N_REGS×32  remaining iteration counts
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement request to the registers
- hwlp_valid_o  out  1  qualifies hwlp_dec_cnt_o; drives the register file's valid input
- hwlp_jump_o  out  1  redirect request to IF
- hwlp_targ_addr_o  out  32  redirect target
- hwlp_active_o  out  N_REGS  bit i = (hwlp_counter_i[i] != 0)
- busy_o  out  1  high while in the HOLD state

## Operation
- Loop i is *active* when counter[i] != 0.
- Loop i *matches* when current_pc_i == end[i] and loop i is active.
- Selected loop: the lowest-index matching loop. This handles nested loops that share an end address: while the inner loop is active it wins; once the inner counter reaches 0, the outer loop is selected.
- hit = pc_valid_i & !kill_i & state==IDLE & (any loop matches).
- On a hit:
  - hwlp_dec_cnt_o = onehot(sel) and hwlp_valid_o = 1. This happens exactly once per hit, regardless of fetch_ready_i.
  - If counter[sel] > 1: hwlp_jump_o = 1 and hwlp_targ_addr_o = start[sel].
  - If counter[sel] == 1: this is the last iteration. The counter decrements to 0, there is no jump, and execution falls through.
- FSM states: IDLE, HOLD.
  - IDLE -> HOLD: a hit with a jump while fetch_ready_i = 0. The target is registered into targ_q.
  - HOLD: hwlp_jump_o = 1 and hwlp_targ_addr_o = targ_q. No new matches are evaluated; hwlp_dec_cnt_o = 0.
  - HOLD -> IDLE: on fetch_ready_i = 1 (the jump is accepted that cycle) or on kill_i = 1 (the jump is dropped and hwlp_jump_o = 0 that cycle).
- kill_i in IDLE: no decrement and no jump in that cycle. kill_i overrides fetch_ready_i.
- Outside a hit and outside HOLD: hwlp_dec_cnt_o = 0, hwlp_valid_o = 0, hwlp_jump_o = 0, hwlp_targ_addr_o = 0.
- Comparisons are 32-bit unsigned. "counter > 1" is evaluated as (counter != 0) & (counter != 1); there is no wrap-around.

## Timing
- Reset values: state = IDLE, targ_q = 0. Outputs: hwlp_jump_o = 0, hwlp_targ_addr_o = 0, hwlp_dec_cnt_o = 0, hwlp_valid_o = 0, busy_o = 0. hwlp_active_o follows its inputs combinationally.
- Match, decrement and jump are combinational in the hit cycle, so the redirect has zero-cycle latency when IF is ready.
- The register file applies the decrement on the next clk edge. A back-to-back hit on the same end PC in the next cycle therefore sees the updated counter.
- HOLD may last any number of cycles; targ_q is stable throughout.
- A reset assertion in the middle of HOLD returns the block to IDLE asynchronously and drops the jump.

## Structure
- Package riscv_hwloop_pkg: the hwlp_state_e enum (IDLE, HOLD) and the HWLP_ADDR_W = 32 constant.
- Sub-module riscv_hwloop_match: per-loop active/match compare plus a lowest-index priority encoder. Outputs: hit, sel index, one-hot vector.
- Top level: the FSM, targ_q, and output muxing.

## Test plan
- start[0]=0x100, end[0]=0x10C, cnt[0]=3, fetch_ready=1. Issue PC 0x10C three times.
  - Required: jumps to 0x100 on the first and second issue; the third issue gives a decrement with no jump; cnt[0] ends at 0.
- Nested loops: end[0]=end[1]=0x200, cnt[0]=1, cnt[1]=2.
  - Required: the first hit decrements loop 0 only, with no jump. The next hit decrements loop 1 and jumps to start[1].
- Hit with jump while fetch_ready=0 for 3 cycles.
  - Required: busy_o=1 and jump held with a constant target for 3 cycles; a single decrement pulse in the hit cycle; return to IDLE on the cycle fetch_ready=1.
- kill_i asserted in HOLD, and separately in a hit cycle.
  - Required: the jump is dropped, no decrement occurs in the kill cycle, and the state is IDLE.
- PC matches end[0] but cnt[0]=0, or pc_valid_i=0.
  - Required: no decrement, no jump, hwlp_active_o[0]=0.
- Assert rst_n asynchronously mid-HOLD.
  - Required: all outputs return to 0 immediately; no jump after release.
